// File: rtl/approx_pkg.sv
// Shared widths and FSM state encoding for the approx_top scheduler slice.
package approx_pkg;
  localparam int unsigned XW = 8;
  localparam int unsigned NW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end
endmodule

// File: rtl/approx_sched.sv
// Round-robin scheduler sharing one approx_top core between NREQ requesters,
// with a watchdog that aborts a job when the core never answers.
module approx_sched
  import approx_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*XW-1:0] x_i,
  input  logic [NREQ*NW-1:0] nIt_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [XW-1:0]      y_o,
  output logic [NREQ-1:0]    valid_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               core_start_o,
  output logic [XW-1:0]      core_x_o,
  output logic [NW-1:0]      core_nIt_o,
  input  logic               core_busy_i,
  input  logic               core_valid_i,
  input  logic [XW-1:0]      core_y_i
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT) + 1;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, id, arb_id;
  logic [NREQ-1:0] arb_grant;
  logic [CW-1:0]   cnt;
  logic            err;
  logic            grant, cap_y, tmo;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_i),
    .ptr   (ptr),
    .grant (arb_grant),
    .id    (arb_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    grant        = 1'b0;
    cap_y        = 1'b0;
    tmo          = 1'b0;
    ack_o        = '0;
    valid_o      = '0;
    err_o        = 1'b0;
    core_start_o = 1'b0;
    busy_o       = (state != IDLE);
    case (state)
      IDLE: begin
        if (|arb_grant && !core_busy_i) begin
          grant    = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        ack_o[id]    = 1'b1;
        core_start_o = 1'b1;
        if (core_valid_i) begin
          cap_y    = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // a valid arriving on the last watchdog cycle still counts as success
        if (core_valid_i) begin
          cap_y    = 1'b1;
          state_nx = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        valid_o[id] = 1'b1;
        err_o       = err;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      id         <= '0;
      core_x_o   <= '0;
      core_nIt_o <= '0;
      y_o        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      if (grant) begin
        id         <= arb_id;
        core_x_o   <= x_i[arb_id*XW +: XW];
        core_nIt_o <= nIt_i[arb_id*NW +: NW];
      end
      if (state == LAUNCH) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (cap_y) begin
        y_o <= core_y_i;
      end else if (tmo) begin
        y_o <= '0;
        err <= 1'b1;
      end
      if (state == DONE) ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    end
  end
endmodule

// File: tb/tb_approx_sched.sv
// Bench for approx_sched: behavioural core (integer sqrt after a programmable
// delay) plus a queue-style round-robin model of which requester is served next.
module tb_approx_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_i;
  logic [NREQ*8-1:0] x_i;
  logic [NREQ*3-1:0] nIt_i;
  logic [NREQ-1:0]   ack_o, valid_o;
  logic [7:0]        y_o, core_x_o;
  logic [2:0]        core_nIt_o;
  logic              err_o, busy_o, core_start_o, core_busy_i;
  logic              core_valid_i = 1'b0;
  logic [7:0]        core_y_i = 8'h00;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  int         core_delay = 5;
  bit         core_never = 1'b0;
  bit         stray      = 1'b0;
  int         cdown      = 0;
  bit         cact       = 1'b0;
  logic [7:0] cres       = 8'h00;

  always #5 clk = ~clk;

  approx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .x_i          (x_i),
    .nIt_i        (nIt_i),
    .ack_o        (ack_o),
    .y_o          (y_o),
    .valid_o      (valid_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .core_start_o (core_start_o),
    .core_x_o     (core_x_o),
    .core_nIt_o   (core_nIt_o),
    .core_busy_i  (core_busy_i),
    .core_valid_i (core_valid_i),
    .core_y_i     (core_y_i)
  );

  function automatic logic [7:0] isqrt(input logic [7:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 8'(r);
  endfunction

  // next requester to serve: first pending one at or after the model pointer
  function automatic int m_pick(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // Behavioural core: valid is asserted for one cycle, core_delay cycles after the start cycle.
  always @(negedge clk) begin
    core_valid_i = 1'b0;
    if (!rst) begin
      cact = 1'b0;
    end else begin
      if (stray) begin
        core_valid_i = 1'b1;
        core_y_i     = 8'hA5;
      end
      if (cact) begin
        if (cdown == 0) begin
          core_valid_i = 1'b1;
          core_y_i     = cres;
          cact         = 1'b0;
        end else begin
          cdown--;
        end
      end
      if (core_start_o) begin
        cres = isqrt(core_x_o);
        if (!core_never) begin
          if (core_delay == 0) begin
            core_valid_i = 1'b1;
            core_y_i     = cres;
          end else begin
            cact  = 1'b1;
            cdown = core_delay - 1;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req_i = '0; x_i = '0; nIt_i = '0; core_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
  endtask

  // Drives one job from requester r and records what the DUT showed; no judging here.
  task automatic run_job(input int r, input logic [7:0] x, input logic [2:0] n,
                         output logic [NREQ-1:0] a_v, output logic [7:0] a_x,
                         output logic [2:0] a_n, output logic a_st, output int lat,
                         output logic [NREQ-1:0] v_v, output logic [7:0] v_y,
                         output logic v_e);
    a_v = '0; a_x = '0; a_n = '0; a_st = 1'b0; lat = -1; v_v = '0; v_y = '0; v_e = 1'b0;
    x_i[8*r +: 8] = x;
    nIt_i[3*r +: 3] = n;
    req_i[r] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack_o !== '0) begin
        a_v = ack_o; a_x = core_x_o; a_n = core_nIt_o; a_st = core_start_o;
        break;
      end
    end
    req_i[r] = 1'b0;
    if (a_v !== '0) begin
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (valid_o !== '0) begin
          lat = i; v_v = valid_o; v_y = y_o; v_e = err_o;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({ack_o, valid_o} !== '0) begin errors++; $display("FAIL reset_ack_valid: got %0h expected 0", {ack_o, valid_o}); end
    checks++; if ({y_o, core_x_o, core_nIt_o} !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", {y_o, core_x_o, core_nIt_o}); end
    checks++; if ({err_o, busy_o, core_start_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {err_o, busy_o, core_start_o}); end
    rst = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", busy_o); end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] a_v, v_v; logic [7:0] a_x, v_y; logic [2:0] a_n; logic a_st, v_e; int lat;
    core_delay = 10;
    run_job(0, 8'd19, 3'd5, a_v, a_x, a_n, a_st, lat, v_v, v_y, v_e);
    checks++; if (a_v !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", a_v); end
    checks++; if (a_st !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", a_st); end
    checks++; if (a_x !== 8'd19 || a_n !== 3'd5) begin errors++; $display("FAIL single_core_in: got x=%0d n=%0d expected x=19 n=5", a_x, a_n); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL single_latency: got %0d expected 11", lat); end
    checks++; if (v_v !== 4'b0001 || v_y !== 8'd4 || v_e !== 1'b0) begin errors++; $display("FAIL single_result: got v=%b y=%0d e=%b expected v=0001 y=4 e=0", v_v, v_y, v_e); end
    m_ptr = 1;
    @(negedge clk);
    checks++; if (valid_o !== '0 || y_o !== 8'd4) begin errors++; $display("FAIL single_hold: got v=%b y=%0d expected v=0000 y=4", valid_o, y_o); end
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] a_v, v_v; logic [7:0] a_x, v_y; logic [2:0] a_n; logic a_st, v_e; int lat; bit bad;
    core_never = 1'b1;
    run_job(2, 8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), a_v, a_x, a_n, a_st, lat, v_v, v_y, v_e);
    core_never = 1'b0;
    checks++; if (a_v !== 4'b0100) begin errors++; $display("FAIL timeout_ack: got %b expected 0100", a_v); end
    checks++; if (lat !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 1); end
    checks++; if (v_v !== 4'b0100 || v_e !== 1'b1 || v_y !== 8'd0) begin errors++; $display("FAIL timeout_result: got v=%b e=%b y=%0d expected v=0100 e=1 y=0", v_v, v_e, v_y); end
    m_ptr = 3;
    @(negedge clk);
    checks++; if (err_o !== 1'b0 || valid_o !== '0) begin errors++; $display("FAIL timeout_pulse: got e=%b v=%b expected e=0 v=0000", err_o, valid_o); end
    #2 stray = 1'b1;
    @(negedge clk);
    #2 stray = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (valid_o !== '0 || y_o !== 8'd0 || busy_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL stray_valid: got v=%b y=%0d expected v=0000 y=0", valid_o, y_o); end
  endtask

  task automatic test_busy();
    logic [7:0] x; bit bad; int lat;
    apply_reset();
    core_busy_i = 1'b1;
    x = 8'($urandom_range(1, 255));
    x_i[15:8] = x;
    nIt_i[5:3] = 3'd2;
    req_i[1] = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack_o !== '0 || core_start_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL busy_block: got ack=%b start=%b expected 0000 0", ack_o, core_start_o); end
    core_busy_i = 1'b0;
    core_delay  = 3;
    @(negedge clk);
    checks++; if (ack_o !== 4'b0010 || core_x_o !== x) begin errors++; $display("FAIL busy_release_ack: got ack=%b x=%0d expected 0010 x=%0d", ack_o, core_x_o, x); end
    req_i[1] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (valid_o !== '0) begin lat = i; break; end
    end
    checks++; if (lat !== 4 || valid_o !== 4'b0010 || y_o !== isqrt(x)) begin errors++; $display("FAIL busy_result: got lat=%0d v=%b y=%0d expected lat=4 v=0010 y=%0d", lat, valid_o, y_o, isqrt(x)); end
    m_ptr = 2;
  endtask

  task automatic test_reset_mid();
    logic [7:0] x0; bit bad; int exp; bit got;
    core_delay = 20;
    x_i[31:24] = 8'($urandom_range(1, 255));
    nIt_i[11:9] = 3'($urandom_range(1, 7));
    req_i[3] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ack_o !== '0) got = 1'b1;
    end
    req_i[3] = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL midrst_ack: got none expected 1000"); end
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({ack_o, valid_o, err_o, busy_o, core_start_o} !== '0) begin errors++; $display("FAIL midrst_ctrl: got %0h expected 0", {ack_o, valid_o, err_o, busy_o, core_start_o}); end
    checks++; if ({y_o, core_x_o, core_nIt_o} !== '0) begin errors++; $display("FAIL midrst_data: got %0h expected 0", {y_o, core_x_o, core_nIt_o}); end
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (valid_o !== '0 || busy_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL midrst_lost_job: got v=%b busy=%b expected none", valid_o, busy_o); end
    core_delay = 2;
    for (int r = 0; r < NREQ; r++) x_i[8*r +: 8] = 8'($urandom_range(0, 255));
    x0 = x_i[7:0];
    exp = m_pick('1);
    req_i = '1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ack_o !== '0) got = 1'b1;
    end
    checks++; if (ack_o !== 4'(1 << exp)) begin errors++; $display("FAIL midrst_ptr: got %b expected %b", ack_o, 4'(1 << exp)); end
    req_i = '0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (valid_o !== '0) got = 1'b1;
    end
    checks++; if (valid_o !== 4'b0001 || y_o !== isqrt(x0)) begin errors++; $display("FAIL midrst_next_job: got v=%b y=%0d expected 0001 y=%0d", valid_o, y_o, isqrt(x0)); end
    m_ptr = 1;
  endtask

  task automatic test_round_robin();
    int left[NREQ]; int pend, exp, cyc, last_valid, any; logic [7:0] pend_x; bit fixed;
    apply_reset();
    for (int round = 0; round < 6; round++) begin
      fixed = (round == 0);
      any = 0;
      for (int r = 0; r < NREQ; r++) begin
        left[r] = fixed ? 2 : $urandom_range(0, 3);
        any += left[r];
      end
      if (any == 0) left[0] = 1;
      for (int r = 0; r < NREQ; r++) begin
        x_i[8*r +: 8]   = fixed ? 8'(10 * (r + 1)) : 8'($urandom_range(0, 255));
        nIt_i[3*r +: 3] = 3'($urandom_range(0, 7));
        req_i[r]        = (left[r] > 0);
      end
      core_delay = $urandom_range(0, 12);
      pend = -1; pend_x = '0; cyc = 0; last_valid = -1;
      while (cyc < 2000) begin
        any = 0;
        for (int r = 0; r < NREQ; r++) any += left[r];
        if (any == 0 && pend < 0) break;
        @(negedge clk);
        cyc++;
        if (ack_o !== '0) begin
          exp = m_pick(req_i);
          checks++; if (exp < 0 || ack_o !== 4'(1 << exp)) begin errors++; $display("FAIL rr_grant: got %b expected id %0d", ack_o, exp); end
          if (last_valid >= 0) begin
            checks++; if (cyc - last_valid != 2) begin errors++; $display("FAIL rr_gap: got %0d expected 2", cyc - last_valid); end
          end
          if (exp >= 0) begin
            checks++; if (core_x_o !== x_i[8*exp +: 8] || core_nIt_o !== nIt_i[3*exp +: 3]) begin errors++; $display("FAIL rr_core_in: got x=%0d n=%0d expected x=%0d n=%0d", core_x_o, core_nIt_o, x_i[8*exp +: 8], nIt_i[3*exp +: 3]); end
            pend = exp;
            pend_x = x_i[8*exp +: 8];
            left[exp]--;
            if (left[exp] > 0) begin
              if (!fixed) x_i[8*exp +: 8] = 8'($urandom_range(0, 255));
              nIt_i[3*exp +: 3] = 3'($urandom_range(0, 7));
            end else begin
              req_i[exp] = 1'b0;
            end
          end
        end
        if (valid_o !== '0) begin
          checks++; if (pend < 0 || valid_o !== 4'(1 << pend) || y_o !== isqrt(pend_x) || err_o !== 1'b0) begin errors++; $display("FAIL rr_result: got v=%b y=%0d e=%b expected id %0d y=%0d e=0", valid_o, y_o, err_o, pend, isqrt(pend_x)); end
          if (pend >= 0) m_ptr = (pend + 1) % NREQ;
          pend = -1;
          last_valid = cyc;
          core_delay = $urandom_range(0, 12);
        end
      end
      checks++; if (cyc >= 2000) begin errors++; $display("FAIL rr_drain: got stuck after %0d cycles expected all jobs served", cyc); end
      req_i = '0;
    end
  endtask

  task automatic test_edges();
    logic [NREQ-1:0] a_v, v_v; logic [7:0] a_x, v_y, x; logic [2:0] a_n; logic a_st, v_e; int lat, r;
    r = $urandom_range(0, NREQ - 1);
    x = 8'($urandom_range(0, 255));
    core_delay = 0;
    run_job(r, x, 3'd0, a_v, a_x, a_n, a_st, lat, v_v, v_y, v_e);
    checks++; if (a_v !== 4'(1 << r) || a_n !== 3'd0) begin errors++; $display("FAIL nit_zero: got ack=%b n=%0d expected ack=%b n=0", a_v, a_n, 4'(1 << r)); end
    checks++; if (lat !== 1 || v_v !== 4'(1 << r) || v_y !== isqrt(x) || v_e !== 1'b0) begin errors++; $display("FAIL launch_valid: got lat=%0d v=%b y=%0d e=%b expected lat=1 y=%0d e=0", lat, v_v, v_y, v_e, isqrt(x)); end
    m_ptr = (r + 1) % NREQ;
    r = $urandom_range(0, NREQ - 1);
    x = 8'($urandom_range(1, 255));
    core_delay = TIMEOUT;
    run_job(r, x, 3'($urandom_range(0, 7)), a_v, a_x, a_n, a_st, lat, v_v, v_y, v_e);
    checks++; if (lat !== TIMEOUT + 1 || v_v !== 4'(1 << r) || v_y !== isqrt(x) || v_e !== 1'b0) begin errors++; $display("FAIL valid_at_timeout: got lat=%0d v=%b y=%0d e=%b expected lat=%0d y=%0d e=0", lat, v_v, v_y, v_e, TIMEOUT + 1, isqrt(x)); end
    m_ptr = (r + 1) % NREQ;
    r = $urandom_range(0, NREQ - 1);
    core_delay = TIMEOUT + 1;
    run_job(r, 8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), a_v, a_x, a_n, a_st, lat, v_v, v_y, v_e);
    checks++; if (lat !== TIMEOUT + 1 || v_v !== 4'(1 << r) || v_y !== 8'd0 || v_e !== 1'b1) begin errors++; $display("FAIL valid_after_timeout: got lat=%0d v=%b y=%0d e=%b expected lat=%0d y=0 e=1", lat, v_v, v_y, v_e, TIMEOUT + 1); end
    m_ptr = (r + 1) % NREQ;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; req_i = '0; x_i = '0; nIt_i = '0; core_busy_i = 1'b0;
    test_reset();
    test_single();
    test_timeout();
    test_busy();
    test_reset_mid();
    test_round_robin();
    test_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
